instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the PC/address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 run  input  1  SHALL be the fetch enable; 0 means no new requests are started.
REQ-006 flush  input  1  SHALL be a one-cycle discard pulse, asserted with the PC replace or add event.
REQ-007 pc  input  ADDR_W  SHALL be the current PC register value.
REQ-008 pc_inc  output  1  SHALL drive the PC increment control.
REQ-009 mem_req  output  1  SHALL be the read request, held until acknowledged.
REQ-010 mem_addr  output  ADDR_W  SHALL be the read address, stable while mem_req=1.
REQ-011 mem_ack  input  1  SHALL be a one-cycle acknowledge that qualifies mem_rdata.
REQ-012 mem_rdata  input  DATA_W  SHALL be the instruction word returned by memory.
REQ-013 ir  output  DATA_W  SHALL be the fetched instruction to decode.
REQ-014 ir_pc  output  ADDR_W  SHALL be the address the instruction in ir was fetched from.
REQ-015 ir_valid  output  1  SHALL mark ir/ir_pc as valid.
REQ-016 ir_ready  input  1  SHALL indicate that decode accepts ir this cycle.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, HOLD and DRAIN.
REQ-018 In IDLE with run=1 and flush=0, the next state SHALL be REQ, with mem_req<=1 and mem_addr<=pc.
REQ-019 In REQ, mem_ack=1 and flush=0 SHALL have these effects:
- capture ir<=mem_rdata, ir_pc<=mem_addr and ir_valid<=1;
- drop mem_req;
- move to HOLD.
REQ-020 pc_inc SHALL be combinational, equal to (state==REQ & mem_ack & ~flush), so the PC advances on the same edge as the capture.
REQ-021 In REQ, flush=1 with mem_ack=0 SHALL move the FSM to DRAIN with mem_req kept asserted and mem_addr unchanged.
REQ-022 In REQ, flush=1 with mem_ack=1 SHALL discard the data, keep pc_inc=0, drop mem_req and move to IDLE.
REQ-023 In DRAIN, mem_ack SHALL discard the data, drop mem_req and move to IDLE; flush in DRAIN SHALL have no further effect.
REQ-024 In HOLD, ir_ready=1 and flush=0 SHALL clear ir_valid and:
- with run=1, move directly to REQ with mem_addr<=pc (the already incremented PC), giving no idle bubble;
- with run=0, move to IDLE.
REQ-025 In HOLD, flush=1 SHALL clear ir_valid and move to IDLE regardless of ir_ready; flush SHALL have priority over ir_ready.
REQ-026 In HOLD, ir, ir_pc and ir_valid SHALL stay stable while ir_ready=0.
REQ-027 run=0 SHALL NOT abort an outstanding request; the request SHALL complete normally.
REQ-028 mem_ack in IDLE or HOLD SHALL be ignored.
REQ-029 At most one request SHALL be outstanding at any time.
REQ-030 The minimum issue-to-capture latency SHALL be one cycle (ack in the first REQ cycle); the steady-state throughput SHALL be one instruction per 2 cycles with a zero-wait memory and ir_ready=1.

Reset
REQ-031 While rst_n=0, all outputs SHALL take these values asynchronously:
- state = IDLE;
- mem_req = 0, mem_addr = 0;
- ir = 0, ir_pc = 0, ir_valid = 0;
- pc_inc = 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; the bench SHALL also reset the memory model.
REQ-033 The first request after rst_n rises SHALL issue no earlier than the second rising edge of clk.

Structure
REQ-034 A shared package fetch_pkg SHALL hold ADDR_W/DATA_W defaults and the state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3).
REQ-035 instr_fetch SHALL be a single module with no sub-modules; the FSM and the ir registers live in it.

Verification
REQ-036 Reset, then run=1, pc=0x0000 and memory with zero wait: the bench SHALL see mem_addr=0x0000 and then ir=mem[0], ir_pc=0x0000, with one pc_inc pulse.
REQ-037 Memory ack delayed 3 cycles: the bench SHALL see mem_req and mem_addr=0x0010 stable for 4 cycles, and ir_valid rise the cycle after ack.
REQ-038 flush at the second REQ cycle with ack 2 cycles later: the bench SHALL see DRAIN, no pc_inc, ir_valid=0, and the next request use the replaced pc=0x0040.
REQ-039 ir_ready=0 for 5 cycles in HOLD: the bench SHALL see ir and ir_pc unchanged, no new mem_req, and REQ entered the cycle after ir_ready=1.
REQ-040 flush and mem_ack in the same REQ cycle: the bench SHALL see data dropped, pc_inc=0, state IDLE, and a refetch from the new pc.
REQ-041 rst_n pulled low during REQ: the bench SHALL see mem_req=0 and ir_valid=0 immediately (asynchronously), and a clean restart from pc after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   DEF_ADDR_W / DEF_DATA_W : default PC and instruction widths
//   fetch_state_t           : FSM encoding, also visible on the debug port
package fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory read at a time from the current
// PC, captures the returned word into the instruction register and hands it
// to decode.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   run                    fetch enable (0: start no new requests)
//   flush                  one-cycle discard pulse, coincides with a PC replace
//   pc                     current PC register value
//   pc_inc                 PC increment strobe (combinational)
//   mem_req/mem_addr       read request and address, held until mem_ack
//   mem_ack/mem_rdata      one-cycle acknowledge qualifying the read data
//   ir/ir_pc/ir_valid      fetched instruction, its address, and valid flag
//   ir_ready               decode accepts ir this cycle
//   state                  FSM state (debug)
//
// Decode handshake: ir/ir_pc are transferred on a cycle where
// ir_valid=1 and ir_ready=1; while ir_valid=1 and ir_ready=0 they hold
// stable. ir_valid never depends combinationally on ir_ready.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output fetch_state_t      state
);

  // Set on the first clock after reset release; holds off the first request
  // until the second rising edge so the PC register has settled.
  logic armed;

  // The PC advances on the same edge the instruction is captured, so the
  // next request (issued from HOLD) already sees the incremented value.
  assign pc_inc = (state == REQ) && mem_ack && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && run && !flush) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end

        // run is ignored here: an issued request always completes.
        REQ: begin
          if (flush) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              // Request stays on the bus; its data is thrown away in DRAIN.
              state <= DRAIN;
            end
          end else if (mem_ack) begin
            ir       <= mem_rdata;
            ir_pc    <= mem_addr;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= HOLD;
          end
        end

        // Flush wins over ir_ready; mem_ack is ignored here.
        HOLD: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            if (run) begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end

        // Waiting out a flushed request; further flushes change nothing.
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a PC register and a variable-latency memory live
// here; directed scenarios are followed by a randomized run checked against
// an instruction-stream model (sequential addresses from the last flush
// target, each word equal to the memory contents at its address).
module tb_instr_fetch;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        run, flush, pc_inc, mem_req, mem_ack, ir_valid, ir_ready;
  logic [15:0] pc_reg, mem_addr, mem_rdata, ir, ir_pc;
  fetch_pkg::fetch_state_t state;

  instr_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .flush    (flush),
    .pc       (pc_reg),
    .pc_inc   (pc_inc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir       (ir),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .state    (state)
  );

  // ---------------- environment: PC register and memory ----------------
  logic        pc_load;
  logic [15:0] pc_target;
  logic [7:0]  ack_delay;
  logic [7:0]  wait_cnt;
  logic        stray_ack;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h2F1B) ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    if (pc_load)     pc_reg <= pc_target;
    else if (pc_inc) pc_reg <= pc_reg + 16'd1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_cnt <= 8'd0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
    else                          wait_cnt <= 8'd0;
  end

  assign mem_ack   = (mem_req && (wait_cnt == ack_delay)) || stray_ack;
  assign mem_rdata = mem_req ? mem_word(mem_addr) : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // previous-cycle samples for the randomized run
  logic        p_req, p_ack, p_valid, p_ready, p_flush, p_inc;
  logic [15:0] p_addr, p_ir, p_ir_pc;
  logic        discard;
  logic [15:0] exp_next;
  int          deliveries;

  initial begin
    rst_n = 1'b0; run = 1'b0; flush = 1'b0; ir_ready = 1'b0;
    pc_load = 1'b1; pc_target = 16'h0000; ack_delay = 8'd0; stray_ack = 1'b0;

    // ---- reset values ----
    tick(); tick();
    check("rst_state", 64'(state), 64'(S_IDLE));
    check("rst_outs", {mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc}, 64'd0);

    // ---- zero-wait first fetch from 0x0000 ----
    rst_n = 1'b1; run = 1'b1; pc_load = 1'b0;
    tick();
    check("first_edge_no_req", 64'(mem_req), 64'd0);
    tick();
    check("t1_req", {state, mem_req, mem_addr}, {S_REQ, 1'b1, 16'h0000});
    check("t1_pc_inc", 64'(pc_inc), 64'd1);
    tick();
    check("t1_capture", {state, ir_valid, ir_pc, ir}, {S_HOLD, 1'b1, 16'h0000, mem_word(16'h0000)});
    check("t1_pc_once", {pc_inc, pc_reg}, {1'b0, 16'h0001});
    run = 1'b0; ir_ready = 1'b1;
    tick();
    check("t1_idle", {state, ir_valid, mem_req}, {S_IDLE, 1'b0, 1'b0});

    // ---- three-cycle wait at 0x0010 ----
    pc_load = 1'b1; pc_target = 16'h0010;
    tick();
    pc_load = 1'b0; run = 1'b1; ack_delay = 8'd3; ir_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_req_stable", {mem_req, mem_addr, ir_valid}, {1'b1, 16'h0010, 1'b0});
      check("t2_pc_inc", 64'(pc_inc), 64'(i == 3));
      tick();
    end
    check("t2_capture", {state, ir_valid, ir_pc, ir}, {S_HOLD, 1'b1, 16'h0010, mem_word(16'h0010)});

    // ---- decode stalls five cycles ----
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold", {state, mem_req, ir_valid, ir_pc, ir}, {S_HOLD, 1'b0, 1'b1, 16'h0010, mem_word(16'h0010)});
    end
    ir_ready = 1'b1;
    tick();
    check("t4_no_bubble", {state, mem_req, mem_addr, ir_valid}, {S_REQ, 1'b1, 16'h0011, 1'b0});

    // ---- flush in the second REQ cycle, ack two cycles later ----
    tick();
    flush = 1'b1; pc_load = 1'b1; pc_target = 16'h0040;
    #1;
    check("t3_flush_no_inc", 64'(pc_inc), 64'd0);
    tick();
    flush = 1'b0; pc_load = 1'b0;
    check("t3_drain", {state, mem_req, mem_addr, pc_reg}, {S_DRAIN, 1'b1, 16'h0011, 16'h0040});
    tick();
    check("t3_drain_ack", {state, mem_ack, pc_inc}, {S_DRAIN, 1'b1, 1'b0});
    tick();
    check("t3_idle", {state, mem_req, ir_valid, pc_reg}, {S_IDLE, 1'b0, 1'b0, 16'h0040});
    tick();
    check("t3_refetch", {state, mem_req, mem_addr}, {S_REQ, 1'b1, 16'h0040});

    // ---- flush together with ack ----
    tick(); tick(); tick();
    flush = 1'b1; pc_load = 1'b1; pc_target = 16'h0080;
    #1;
    check("t5_ack_flush_inc", {mem_ack, pc_inc}, {1'b1, 1'b0});
    tick();
    flush = 1'b0; pc_load = 1'b0;
    check("t5_dropped", {state, mem_req, ir_valid, pc_reg}, {S_IDLE, 1'b0, 1'b0, 16'h0080});
    tick();
    check("t5_refetch", {state, mem_req, mem_addr}, {S_REQ, 1'b1, 16'h0080});

    // ---- asynchronous reset mid-request ----
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_async", {state, mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc}, {S_IDLE, 50'd0});
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t6_wait_edge", 64'(mem_req), 64'd0);
    tick();
    check("t6_restart", {state, mem_req, mem_addr}, {S_REQ, 1'b1, 16'h0080});
    begin
      int n = 0;
      while (!ir_valid && n < 10) begin
        tick();
        n++;
      end
    end
    check("t6_capture", {ir_valid, ir_pc, ir}, {1'b1, 16'h0080, mem_word(16'h0080)});

    // ---- randomized run against the stream model ----
    deliveries = 0;
    discard = 1'b0;
    exp_next = 16'h0000;
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      if (cyc != 0) begin
        if (p_req && !p_ack)
          check("r_req_held", {mem_req, mem_addr}, {1'b1, p_addr});
        else if (p_req && p_ack)
          check("r_req_drop", 64'(mem_req), 64'd0);
        if (p_inc)
          check("r_capture", {ir_valid, ir_pc, ir}, {1'b1, p_addr, mem_word(p_addr)});
        else if (p_valid && !p_ready && !p_flush)
          check("r_ir_stable", {ir_valid, ir_pc, ir}, {1'b1, p_ir_pc, p_ir});
        else
          check("r_ir_invalid", 64'(ir_valid), 64'd0);
      end

      if (!mem_req) ack_delay = 8'($urandom_range(0, 3));
      stray_ack = !mem_req && ($urandom_range(0, 4) == 0);
      run       = ($urandom_range(0, 9) != 0);
      ir_ready  = ($urandom_range(0, 2) != 0);
      flush     = (cyc == 0) || ($urandom_range(0, 15) == 0);
      pc_load   = flush;
      pc_target = 16'($urandom_range(0, 16'hFFF0));
      #1;

      if (pc_inc)
        check("r_inc_cause", {mem_req, mem_ack, flush}, {1'b1, 1'b1, 1'b0});
      if (mem_req && mem_ack) begin
        if (discard) check("r_drain_discard", 64'(pc_inc), 64'd0);
        discard = 1'b0;
      end else if (flush && mem_req) begin
        discard = 1'b1;
      end

      if (ir_valid && ir_ready && !flush) begin
        check("r_stream_pc", 64'(ir_pc), 64'(exp_next));
        check("r_stream_word", 64'(ir), 64'(mem_word(ir_pc)));
        exp_next = exp_next + 16'd1;
        deliveries++;
      end
      if (flush) exp_next = pc_target;

      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
      p_valid = ir_valid; p_ready = ir_ready; p_flush = flush; p_inc = pc_inc;
      p_ir = ir; p_ir_pc = ir_pc;
    end
    flush = 1'b0; pc_load = 1'b0; stray_ack = 1'b0;
    check("r_liveness", 64'(deliveries > 20), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
